traffic_phase_ctrl: RTL
=======================

TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 Parameter N_PHASES, default 4: number of signal phases (approaches); range 2..16.
REQ-002 Parameter CNT_W, default 5: width of each per-phase vehicle count.
REQ-003 Parameter TMR_W, default 8: width of the phase timer.
REQ-004 Parameters GREEN_MIN=10, GREEN_MAX=40, YELLOW_T=4, ALLRED_T=2: durations in ticks; GREEN_MIN<=GREEN_MAX<2**TMR_W.
REQ-005 Port clk, input, 1: single clock, rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-low reset (0 = reset).
REQ-007 Port tick, input, 1: one-clk timebase pulse; all timers advance only on tick.
REQ-008 Port veh_cnt, input, N_PHASES*CNT_W: queued vehicles per phase; phase i occupies bits [i*CNT_W +: CNT_W].
REQ-009 Port emerg_req, input, 1: emergency preemption request, level-sensitive.
REQ-010 Port emerg_phase, input, clog2(N_PHASES): phase to serve during preemption.
REQ-011 Port lights, output, 3*N_PHASES: per-phase {red,yellow,green}; 100 red, 010 yellow, 001 green.
REQ-012 Port active_phase, output, clog2(N_PHASES): phase currently served or last served.
REQ-013 Port state, output, 2: FSM state code.

Function
REQ-014 FSM states: ALL_RED=0, GREEN=1, YELLOW=2, PREEMPT=3; state and timer update only on clk edges with tick=1, except preemption entry.
REQ-015 Exactly one phase is non-red in GREEN, YELLOW and PREEMPT; all phases are red in ALL_RED.
REQ-016 Outputs are registered: lights reflect the new state in the same clk cycle the state register changes.
REQ-017 Timer clears on every state entry and increments per tick, saturating at 2**TMR_W-1.
REQ-018 ALL_RED: after ALLRED_T ticks, pick next phase round-robin from active_phase+1 (wrapping N_PHASES-1 to 0) to the first phase with veh_cnt>0; go to GREEN.
REQ-019 ALL_RED with no phase demanding: remain in ALL_RED and re-evaluate on every tick.
REQ-020 ALL_RED round-robin includes active_phase itself last, so a sole demanding phase is re-served.
REQ-021 GREEN: go to YELLOW once timer>=GREEN_MIN and own veh_cnt==0, or when timer reaches GREEN_MAX regardless of count.
REQ-022 YELLOW: after YELLOW_T ticks go to ALL_RED.
REQ-023 emerg_req rising while in GREEN on phase != emerg_phase: go to YELLOW on the next clk, ignoring GREEN_MIN.
REQ-024 emerg_req in GREEN on emerg_phase: go to PREEMPT on the next clk, without a yellow interval.
REQ-025 emerg_req in YELLOW: complete YELLOW normally. In ALL_RED: after ALLRED_T, go to PREEMPT on emerg_phase and bypass round-robin.
REQ-026 PREEMPT: emerg_phase green while emerg_req=1; on deassertion go to YELLOW, then the normal sequence; active_phase=emerg_phase.
REQ-027 emerg_phase changing during PREEMPT: go YELLOW, ALL_RED, then PREEMPT on the new phase.
REQ-028 emerg_phase >= N_PHASES: request ignored.
REQ-029 Direct green-to-green is prohibited for any two distinct phases; an ALL_RED of >=ALLRED_T ticks always separates them.

Reset
REQ-030 On rst=0: state=ALL_RED, timer=0, active_phase=N_PHASES-1 (first service scans from phase 0), all lights=100.
REQ-031 Reset asserted mid-GREEN or mid-PREEMPT forces all red immediately (asynchronous) with no yellow interval.
REQ-032 After rst release, the first GREEN occurs no earlier than ALLRED_T ticks later.

Structure
REQ-033 Shared package traffic_pkg holds the state enum, the light-code constants (RED, YEL, GRN), and the timer-width default.
REQ-034 Sub-module phase_arbiter (combinational round-robin next-demanding-phase finder, parametrised by N_PHASES and CNT_W) is instantiated once.

Verification
REQ-035 Reset, then veh_cnt phase0=3, others 0: all red for 2 ticks, then phase0 001; count to 0 at tick 5; yellow at tick 10 (GREEN_MIN), red 4 ticks later.
REQ-036 Phase1 count held at 9: phase1 green exactly 40 ticks, then 4 ticks yellow, 2 ticks all red, then phase1 green again (sole demand).
REQ-037 Phases 0,2,3 demanding, active_phase=0: service order 2, 3, 0; phase1 is skipped.
REQ-038 Phase0 green at tick 3, emerg_req=1 with emerg_phase=2: phase0 yellow on next clk, then 4 yellow ticks, 2 all-red ticks, phase2 green held until emerg_req=0, then phase2 yellow.
REQ-039 No demand for 50 ticks: all lights stay 100 and state=ALL_RED throughout; assertion that at most one phase is ever non-red holds.
REQ-040 rst pulsed low mid-YELLOW asynchronously: lights=all 100 within the same cycle, no clk edge required.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase controller: state codes, light codes
// and the default timer width.
package traffic_pkg;

    // Controller state encoding (visible on the state output).
    typedef logic [1:0] state_t;
    localparam state_t ST_ALL_RED = 2'd0;
    localparam state_t ST_GREEN   = 2'd1;
    localparam state_t ST_YELLOW  = 2'd2;
    localparam state_t ST_PREEMPT = 2'd3;

    // Per-phase light code, packed as {red, yellow, green}.
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam int unsigned TMR_W_DEFAULT = 8;

endpackage

// File: rtl/phase_arbiter.sv
// Combinational round-robin finder: starting after last_phase and wrapping,
// returns the first phase with a non-zero vehicle count. last_phase itself is
// scanned last, so a sole demanding phase is served again.
module phase_arbiter #(
    parameter int unsigned N_PHASES = 4,
    parameter int unsigned CNT_W    = 5
) (
    input  logic [N_PHASES*CNT_W-1:0]   veh_cnt,
    input  logic [$clog2(N_PHASES)-1:0] last_phase,
    output logic [$clog2(N_PHASES)-1:0] next_phase,
    output logic                        next_valid
);

    localparam int unsigned PW = $clog2(N_PHASES);

    int idx;

    // Scan from the farthest offset to the nearest so the nearest demand wins.
    always_comb begin
        next_phase = last_phase;
        next_valid = 1'b0;
        idx        = 0;
        for (int k = int'(N_PHASES); k >= 1; k--) begin
            idx = int'(last_phase) + k;
            if (idx >= int'(N_PHASES)) begin
                idx = idx - int'(N_PHASES);
            end
            if (veh_cnt[idx*int'(CNT_W) +: CNT_W] != '0) begin
                next_phase = PW'(idx);
                next_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Demand-actuated traffic signal controller with emergency preemption.
// One phase at a time is served; every change between distinct phases passes
// through yellow and an all-red clearance interval. All timing is counted in
// tick pulses; outputs are registered alongside the state.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned N_PHASES  = 4,
    parameter int unsigned CNT_W     = 5,
    parameter int unsigned TMR_W     = TMR_W_DEFAULT,
    parameter int unsigned GREEN_MIN = 10,
    parameter int unsigned GREEN_MAX = 40,
    parameter int unsigned YELLOW_T  = 4,
    parameter int unsigned ALLRED_T  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tick,
    input  logic [N_PHASES*CNT_W-1:0]   veh_cnt,
    input  logic                        emerg_req,
    input  logic [$clog2(N_PHASES)-1:0] emerg_phase,
    output logic [3*N_PHASES-1:0]       lights,
    output logic [$clog2(N_PHASES)-1:0] active_phase,
    output logic [1:0]                  state
);

    localparam int unsigned PW = $clog2(N_PHASES);

    localparam logic [TMR_W-1:0] GMIN_LIM   = TMR_W'(GREEN_MIN);
    localparam logic [TMR_W-1:0] GMAX_LIM   = TMR_W'(GREEN_MAX);
    localparam logic [TMR_W-1:0] YEL_LIM    = TMR_W'(YELLOW_T);
    localparam logic [TMR_W-1:0] ALLRED_LIM = TMR_W'(ALLRED_T);

    state_t                state_q, state_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d, tmr_inc;
    logic [PW-1:0]         phase_q, phase_d;
    logic [3*N_PHASES-1:0] lights_q, lights_d;

    logic          emerg_valid;
    logic          own_empty;
    logic [PW-1:0] arb_phase;
    logic          arb_valid;

    phase_arbiter #(
        .N_PHASES (N_PHASES),
        .CNT_W    (CNT_W)
    ) u_arbiter (
        .veh_cnt    (veh_cnt),
        .last_phase (phase_q),
        .next_phase (arb_phase),
        .next_valid (arb_valid)
    );

    // Request qualification and timer arithmetic shared by every state.
    always_comb begin
        // Out-of-range emergency phases are treated as no request.
        emerg_valid = emerg_req && (int'(emerg_phase) < int'(N_PHASES));
        own_empty   = (veh_cnt[int'(phase_q)*int'(CNT_W) +: CNT_W] == '0);
        tmr_inc     = (tmr_q == '1) ? tmr_q : tmr_q + TMR_W'(1);
    end

    // Next-state logic. Comparisons use the post-increment timer so that a
    // duration of T means exactly T ticks spent in the state.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        phase_d = phase_q;
        case (state_q)
            ST_ALL_RED: begin
                if (tick) begin
                    tmr_d = tmr_inc;
                    if (tmr_inc >= ALLRED_LIM) begin
                        if (emerg_valid) begin
                            state_d = ST_PREEMPT;
                            phase_d = emerg_phase;
                            tmr_d   = '0;
                        end else if (arb_valid) begin
                            state_d = ST_GREEN;
                            phase_d = arb_phase;
                            tmr_d   = '0;
                        end
                        // No demand: stay here and re-evaluate on the next tick.
                    end
                end
            end
            ST_GREEN: begin
                // Emergency acts on the next clock, independent of tick.
                if (emerg_valid) begin
                    state_d = (emerg_phase == phase_q) ? ST_PREEMPT : ST_YELLOW;
                    tmr_d   = '0;
                end else if (tick) begin
                    tmr_d = tmr_inc;
                    if ((tmr_inc >= GMAX_LIM) || ((tmr_inc >= GMIN_LIM) && own_empty)) begin
                        state_d = ST_YELLOW;
                        tmr_d   = '0;
                    end
                end
            end
            ST_YELLOW: begin
                if (tick) begin
                    tmr_d = tmr_inc;
                    if (tmr_inc >= YEL_LIM) begin
                        state_d = ST_ALL_RED;
                        tmr_d   = '0;
                    end
                end
            end
            ST_PREEMPT: begin
                // A dropped request or a different target both leave via yellow.
                if (tick) begin
                    tmr_d = tmr_inc;
                    if (!emerg_valid || (emerg_phase != phase_q)) begin
                        state_d = ST_YELLOW;
                        tmr_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_ALL_RED;
                tmr_d   = '0;
            end
        endcase
    end

    // Light pattern for the upcoming state, so it is registered with it.
    always_comb begin
        lights_d = '0;
        for (int i = 0; i < int'(N_PHASES); i++) begin
            lights_d[3*i +: 3] = RED;
            if ((state_d != ST_ALL_RED) && (int'(phase_d) == i)) begin
                lights_d[3*i +: 3] = (state_d == ST_YELLOW) ? YEL : GRN;
            end
        end
    end

    // State, timer, served phase and lights; reset forces all red at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_ALL_RED;
            tmr_q    <= '0;
            phase_q  <= PW'(N_PHASES - 1);
            lights_q <= {N_PHASES{RED}};
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            phase_q  <= phase_d;
            lights_q <= lights_d;
        end
    end

    assign lights       = lights_q;
    assign active_phase = phase_q;
    assign state        = state_q;

endmodule
